// File: rtl/noc_output_arbiter.sv
`default_nettype none
// =============================================================================
// noc_output_arbiter : wormhole output-port arbiter with round-robin head
//                      selection and credit-based downstream flow control
// Revision 1.0
// =============================================================================

package noc_arb_pkg;
   localparam int Noc_Flit_Width    = 32;
   localparam int Noc_VC_Fifo_Depth = 4;
endpackage

module noc_output_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_REQ    = 5,
   parameter int FLIT_W     = Noc_Flit_Width,
   parameter int CREDIT_MAX = Noc_VC_Fifo_Depth
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_head,
   input  logic [NUM_REQ-1:0]        req_tail,
   input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [FLIT_W-1:0]         out_flit,
   output logic                      out_tail,
   input  logic                      credit_return,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      credit_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SUM_W = IDX_W + 1;
   localparam int CNT_W = $clog2(CREDIT_MAX + 1);
   localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(CREDIT_MAX);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]     credits_q, credits_d;
   logic                 credit_err_q, credit_err_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_tail_q, out_tail_d;
   logic [FLIT_W-1:0]    out_flit_q, out_flit_d;

   logic [NUM_REQ-1:0]   candidates;
   logic [IDX_W-1:0]     winner;
   logic                 winner_found;
   logic [SUM_W-1:0]     scan_idx;
   logic                 has_credit;
   logic                 accept;
   logic                 owner_tail;
   logic [FLIT_W-1:0]    owner_flit;

   assign candidates = req_valid & req_head;
   assign has_credit = (credits_q != '0);
   assign accept     = (state_q == LOCKED) && req_valid[owner_q] && has_credit;
   assign owner_tail = req_tail[owner_q];
   assign owner_flit = req_flit[owner_q*FLIT_W +: FLIT_W];

   // Scan offsets high-to-low so the closest candidate at or above rr_ptr wins last.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      scan_idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = {1'b0, rr_ptr_q} + SUM_W'(k);
         if (scan_idx >= SUM_W'(NUM_REQ)) begin
            scan_idx = scan_idx - SUM_W'(NUM_REQ);
         end
         if (candidates[scan_idx[IDX_W-1:0]]) begin
            winner       = scan_idx[IDX_W-1:0];
            winner_found = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == LOCKED) begin
         req_ready[owner_q] = has_credit;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      out_valid_d  = accept;
      out_flit_d   = out_flit_q;
      out_tail_d   = out_tail_q;

      if (accept) begin
         out_flit_d = owner_flit;
         out_tail_d = owner_tail;
      end

      // A same-cycle accept and return cancel out.
      if (accept && !credit_return) begin
         credits_d = credits_q - CNT_W'(1);
      end else if (!accept && credit_return) begin
         if (credits_q == CREDIT_FULL) begin
            credit_err_d = 1'b1;
         end else begin
            credits_d = credits_q + CNT_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (winner_found) begin
               state_d = LOCKED;
               owner_d = winner;
               grant_d = NUM_REQ'(1) << winner;
            end
         end
         LOCKED: begin
            if (accept && owner_tail) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         credits_q    <= CREDIT_FULL;
         credit_err_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_flit_q   <= '0;
         out_tail_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
         out_valid_q  <= out_valid_d;
         out_flit_q   <= out_flit_d;
         out_tail_q   <= out_tail_d;
      end
   end

   assign grant      = grant_q;
   assign credit_err = credit_err_q;
   assign out_valid  = out_valid_q;
   assign out_flit   = out_flit_q;
   assign out_tail   = out_tail_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_output_arbiter.sv
`default_nettype none
// tb_noc_output_arbiter : directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the arbiter.
module tb_noc_output_arbiter;

   localparam int N  = 5;
   localparam int FW = 8;
   localparam int CM = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid, req_head, req_tail, req_ready, grant;
   logic [N*FW-1:0] req_flit;
   logic            out_valid, out_tail, credit_return, credit_err;
   logic [FW-1:0]   out_flit;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit            m_locked;
   int            m_owner, m_rr, m_credits;
   bit            m_err, m_ov, m_ot;
   logic [FW-1:0] m_of;

   always #5 clk = ~clk;

   noc_output_arbiter #(.NUM_REQ(N), .FLIT_W(FW), .CREDIT_MAX(CM)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
      .req_flit(req_flit), .req_ready(req_ready),
      .out_valid(out_valid), .out_flit(out_flit), .out_tail(out_tail),
      .credit_return(credit_return), .grant(grant), .credit_err(credit_err)
   );

   function automatic logic [N-1:0] exp_ready();
      if (m_locked && m_credits > 0) return N'(1) << m_owner;
      return {N{1'b0}};
   endfunction

   function automatic logic [N-1:0] exp_grant();
      if (m_locked) return N'(1) << m_owner;
      return {N{1'b0}};
   endfunction

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_rr = 0; m_credits = CM;
      m_err = 0; m_ov = 0; m_ot = 0; m_of = '0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit acc;
      acc = m_locked && req_valid[m_owner] && (m_credits > 0);
      m_ov = acc;
      if (acc) begin
         m_of = req_flit[m_owner*FW +: FW];
         m_ot = req_tail[m_owner];
      end
      if (acc && !credit_return) m_credits--;
      else if (!acc && credit_return) begin
         if (m_credits == CM) m_err = 1;
         else m_credits++;
      end
      if (!m_locked) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (!m_locked && req_valid[idx] && req_head[idx]) begin
               m_locked = 1;
               m_owner  = idx;
            end
         end
      end else if (acc && req_tail[m_owner]) begin
         m_locked = 0;
         m_rr     = (m_owner + 1) % N;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_head = '0; req_tail = '0; req_flit = '0;
      credit_return = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      req_valid = '1; req_head = '1;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      n_checks++; if (grant !== 5'b0) $display("FAIL reset_grant: got %b want 00000", grant); else n_pass++;
      n_checks++; if (req_ready !== 5'b0) $display("FAIL reset_ready: got %b want 00000", req_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_flit !== 8'h00) $display("FAIL reset_out_flit: got %h want 00", out_flit); else n_pass++;
      n_checks++; if (out_tail !== 1'b0) $display("FAIL reset_out_tail: got %b want 0", out_tail); else n_pass++;
      n_checks++; if (credit_err !== 1'b0) $display("FAIL reset_credit_err: got %b want 0", credit_err); else n_pass++;
      clear_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int           fc[N];
      int           order[$];
      int           exp_order[4];
      logic [N-1:0] acc, prev_grant;
      bit           head_pending;
      logic [FW-1:0] head_val;
      apply_reset();
      exp_order = '{0, 2, 4, 0};
      foreach (fc[i]) fc[i] = 0;
      prev_grant = '0;
      for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
         for (int i = 0; i < N; i += 2) begin
            req_valid[i] = 1'b1;
            req_head[i]  = (fc[i] == 0);
            req_tail[i]  = (fc[i] == 1);
            req_flit[i*FW +: FW] = FW'(i * 16 + fc[i]);
         end
         credit_return = m_ov;
         acc = req_ready & req_valid;
         head_pending = 0;
         head_val = '0;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && fc[i] == 0) begin
               head_pending = 1;
               head_val = FW'(i * 16);
            end
         end
         tick();
         if (head_pending) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_flit !== head_val)
               $display("FAIL rr_head_latency: got valid=%b flit=%h want valid=1 flit=%h", out_valid, out_flit, head_val);
            else n_pass++;
         end
         for (int i = 0; i < N; i++) if (acc[i]) fc[i] = (fc[i] + 1) % 2;
         if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
         end
         prev_grant = grant;
      end
      for (int j = 0; j < 4; j++) begin
         int got;
         got = (j < order.size()) ? order[j] : -1;
         n_checks++;
         if (got !== exp_order[j]) $display("FAIL rr_order[%0d]: got %0d want %0d", j, got, exp_order[j]);
         else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_credit_stall();
      int fc, accepts;
      apply_reset();
      fc = 0; accepts = 0;
      for (int cyc = 0; cyc < 18; cyc++) begin
         if (cyc == 12) begin
            n_checks++; if (accepts !== 4) $display("FAIL stall_accepts: got %0d want 4", accepts); else n_pass++;
            n_checks++; if (req_ready !== 5'b0) $display("FAIL stall_ready: got %b want 00000", req_ready); else n_pass++;
         end
         credit_return = (cyc == 12);
         req_valid[0] = (fc < 6);
         req_head[0]  = (fc == 0);
         req_tail[0]  = (fc == 5);
         req_flit[0 +: FW] = FW'(fc);
         if (req_valid[0] && req_ready[0]) begin
            accepts++; fc++;
         end
         tick();
      end
      n_checks++; if (accepts !== 5) $display("FAIL stall_after_return: got %0d want 5", accepts); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_single_flit();
      apply_reset();
      req_valid[3] = 1'b1; req_head[3] = 1'b1; req_tail[3] = 1'b1;
      req_flit[3*FW +: FW] = 8'hA5;
      n_checks++; if (req_ready !== 5'b0) $display("FAIL single_bubble_ready: got %b want 00000", req_ready); else n_pass++;
      tick();
      n_checks++; if (grant !== 5'b01000) $display("FAIL single_grant: got %b want 01000", grant); else n_pass++;
      n_checks++; if (req_ready !== 5'b01000) $display("FAIL single_ready: got %b want 01000", req_ready); else n_pass++;
      tick();
      clear_inputs();
      n_checks++; if (out_valid !== 1'b1 || out_flit !== 8'hA5 || out_tail !== 1'b1)
         $display("FAIL single_out: got v=%b f=%h t=%b want v=1 f=a5 t=1", out_valid, out_flit, out_tail);
      else n_pass++;
      n_checks++; if (grant !== 5'b0) $display("FAIL single_grant_clear: got %b want 00000", grant); else n_pass++;
      req_valid = 5'b10001; req_head = 5'b10001; req_tail = 5'b10001;
      tick();
      n_checks++; if (grant !== 5'b10000) $display("FAIL single_rr_next: got %b want 10000", grant); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_simultaneous();
      int accepts;
      apply_reset();
      req_valid[0] = 1'b1; req_head[0] = 1'b1; req_flit[0 +: FW] = 8'h11;
      tick();
      req_head[0] = 1'b0;
      tick();
      tick();
      credit_return = 1'b1;
      n_checks++; if (req_ready !== 5'b00001) $display("FAIL simul_ready: got %b want 00001", req_ready); else n_pass++;
      tick();
      credit_return = 1'b0;
      accepts = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (req_valid[0] && req_ready[0]) accepts++;
         tick();
      end
      n_checks++; if (accepts !== 2) $display("FAIL simul_credits_kept: got %0d want 2", accepts); else n_pass++;
      req_valid[0] = 1'b0;
      credit_return = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) tick();
      credit_return = 1'b0;
      n_checks++; if (credit_err !== 1'b0) $display("FAIL simul_err_early: got %b want 0", credit_err); else n_pass++;
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      tick();
      n_checks++; if (credit_err !== 1'b1) $display("FAIL simul_err_set: got %b want 1", credit_err); else n_pass++;
      req_valid[0] = 1'b1;
      accepts = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (req_valid[0] && req_ready[0]) accepts++;
         tick();
      end
      n_checks++; if (accepts !== 4) $display("FAIL simul_credits_capped: got %0d want 4", accepts); else n_pass++;
      n_checks++; if (credit_err !== 1'b1) $display("FAIL simul_err_sticky: got %b want 1", credit_err); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_non_head();
      int bad;
      apply_reset();
      req_valid[1] = 1'b1; req_head[1] = 1'b0; req_flit[1*FW +: FW] = 8'h3C;
      bad = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         req_tail[1] = cyc[0];
         tick();
         if (grant !== 5'b0 || req_ready !== 5'b0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL non_head_ignored: got %0d bad cycles want 0", bad); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      int accepts;
      apply_reset();
      // single-flit packet from requester 1 moves the pointer to 2
      req_valid[1] = 1'b1; req_head[1] = 1'b1; req_tail[1] = 1'b1;
      tick(); tick();
      clear_inputs();
      req_valid[0] = 1'b1; req_head[0] = 1'b1; req_flit[0 +: FW] = 8'h40;
      tick();
      req_head[0] = 1'b0; req_flit[0 +: FW] = 8'h41;
      tick();
      req_flit[0 +: FW] = 8'h42;
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (grant !== 5'b0) $display("FAIL mid_grant: got %b want 00000", grant); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (req_ready !== 5'b0) $display("FAIL mid_ready: got %b want 00000", req_ready); else n_pass++;
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = 5'b01001; req_head = 5'b01001;
      tick();
      n_checks++; if (grant !== 5'b00001) $display("FAIL mid_first_grant: got %b want 00001", grant); else n_pass++;
      req_head = '0;
      accepts = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (req_valid[0] && req_ready[0]) accepts++;
         tick();
      end
      n_checks++; if (accepts !== 4) $display("FAIL mid_credits_full: got %0d want 4", accepts); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_random();
      for (int round = 0; round < 2; round++) begin
         apply_reset();
         for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
               req_valid[i] = ($urandom_range(0, 3) != 0);
               req_head[i]  = $urandom_range(0, 1);
               req_tail[i]  = ($urandom_range(0, 2) == 0);
               req_flit[i*FW +: FW] = FW'($urandom);
            end
            credit_return = (round == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            n_checks++; if (req_ready !== exp_ready()) $display("FAIL rand_ready: got %b want %b", req_ready, exp_ready()); else n_pass++;
            n_checks++; if (grant !== exp_grant()) $display("FAIL rand_grant: got %b want %b", grant, exp_grant()); else n_pass++;
            n_checks++; if (out_valid !== m_ov) $display("FAIL rand_out_valid: got %b want %b", out_valid, m_ov); else n_pass++;
            if (m_ov) begin
               n_checks++;
               if (out_flit !== m_of || out_tail !== m_ot)
                  $display("FAIL rand_out_data: got f=%h t=%b want f=%h t=%b", out_flit, out_tail, m_of, m_ot);
               else n_pass++;
            end
            n_checks++; if (credit_err !== m_err) $display("FAIL rand_credit_err: got %b want %b", credit_err, m_err); else n_pass++;
            tick();
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      #2;
      test_reset();
      test_round_robin();
      test_credit_stall();
      test_single_flit();
      test_simultaneous();
      test_non_head();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/noc_output_arbiter.md
NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, meaning the number of requesting input ports; index 0..4 maps to EAST, WEST, SOUTH, NORTH, LOCAL, in the bit order of the route encoding.
REQ-002 SHALL have parameter FLIT_W, default Noc_Flit_Width, meaning the flit width in bits.
REQ-003 SHALL have parameter CREDIT_MAX, default Noc_VC_Fifo_Depth, meaning the downstream buffer depth in flits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, meaning a flit is offered by requester i.
REQ-007 SHALL have port req_head, input, NUM_REQ, meaning the offered flit is a head flit.
REQ-008 SHALL have port req_tail, input, NUM_REQ, meaning the offered flit is a tail flit; head and tail may both be set for a single-flit packet.
REQ-009 SHALL have port req_flit, input, NUM_REQ*FLIT_W, meaning the flit payloads, with requester i at bits [i*FLIT_W +: FLIT_W].
REQ-010 SHALL have port req_ready, output, NUM_REQ, meaning the flit of requester i is accepted this cycle.
REQ-011 SHALL have port out_valid, output, 1, meaning out_flit is valid this cycle.
REQ-012 SHALL have port out_flit, output, FLIT_W, meaning the forwarded flit.
REQ-013 SHALL have port out_tail, output, 1, meaning out_flit is a tail flit.
REQ-014 SHALL have port credit_return, input, 1, meaning a one-cycle pulse that frees one downstream slot.
REQ-015 SHALL have port grant, output, NUM_REQ, meaning the one-hot current owner (all zero when idle).
REQ-016 SHALL have port credit_err, output, 1, meaning a sticky flag for a credit counter overflow.

Function
REQ-017 SHALL implement the states IDLE and LOCKED.
REQ-018 In IDLE, SHALL select a winner among requesters with req_valid & req_head, round-robin, searching from rr_ptr upward with wrap-around.
REQ-019 In IDLE with at least one candidate, SHALL register the winner as owner, set grant, and go to LOCKED on the next edge; req_ready SHALL be all zero during IDLE (one-cycle arbitration bubble).
REQ-020 In IDLE, SHALL ignore requesters that offer a non-head flit.
REQ-021 In LOCKED, SHALL drive req_ready[owner] = (credits > 0) and all other req_ready bits to 0.
REQ-022 SHALL define an accept as req_valid[owner] & req_ready[owner].
REQ-023 On an accept, SHALL register out_flit and out_tail from the owner and assert out_valid on the next cycle (latency 1); otherwise out_valid SHALL be 0 on the next cycle.
REQ-024 On an accept with req_tail set, SHALL go to IDLE, set rr_ptr = (owner+1) mod NUM_REQ, and clear grant.
REQ-025 When the owner drops req_valid mid-packet, SHALL remain LOCKED, with the wormhole held.
REQ-026 SHALL keep credits in the range 0..CREDIT_MAX, decrement by 1 on each accept, and increment by 1 on each credit_return pulse.
REQ-027 On a simultaneous accept and credit_return, SHALL leave credits unchanged.
REQ-028 On a credit_return with credits == CREDIT_MAX and no accept, SHALL hold credits at CREDIT_MAX and set credit_err until reset.
REQ-029 SHALL never accept a flit when credits == 0.
REQ-030 SHALL make rr_ptr advance only on a tail accept.

Reset
REQ-031 While rst_n is low, SHALL set: state IDLE, rr_ptr 0, grant 0, req_ready 0, out_valid 0, out_flit 0, out_tail 0, credits CREDIT_MAX, credit_err 0.
REQ-032 On reset asserted mid-packet, SHALL discard the packet lock immediately (asynchronously).
REQ-033 After reset, SHALL resume arbitration from requester 0.

Verification
REQ-034 Round-robin: requesters 0, 2 and 4 hold 2-flit packets continuously, with credits returned each cycle -> packets are granted in order 0, 2, 4, 0; each head appears on out one cycle after its accept.
REQ-035 Credit stall: CREDIT_MAX=4, no credit_return, owner offers a 6-flit packet -> 4 flits are accepted, req_ready drops to 0; one credit_return pulse -> exactly 1 more flit is accepted.
REQ-036 Single-flit packet: requester 3 offers head+tail with value 0xA5 -> grant=5'b01000 for one accept cycle; out_flit=0xA5 with out_tail=1 on the next cycle; state returns to IDLE; rr_ptr=4.
REQ-037 Simultaneous events: accept with credit_return in the same cycle at credits=2 -> credits remain 2; credit_return at credits=4 -> credit_err=1 and credits stay 4.
REQ-038 Non-head ignored: in IDLE, requester 1 offers a body flit only -> grant stays 0 and req_ready stays 0 indefinitely.
REQ-039 Reset mid-packet: assert rst_n=0 after 2 of 4 flits -> grant=0, out_valid=0, credits=4 at once; after release, requester 0 is granted first.
